// File: rtl/pico_pkg.sv
// Shared definitions for pico cores: opcodes, FSM states and instruction-field helpers.
// Field helpers take the widths as arguments so every core variant can share them.
package pico_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_ADDI = 4'd9,
    OP_BEQZ = 4'd10,
    OP_JMP  = 4'd11,
    OP_IN   = 4'd12,
    OP_OUT  = 4'd13,
    OP_HALT = 4'd14,
    OP_RSV  = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT     = 3'd1,
    S_EXEC     = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_e;

  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] wide_t;

  function automatic wide_t fmask(input int w);
    return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic logic [3:0] ins_op(input wide_t ins, input int iw);
    return 4'(ins >> (iw - 4));
  endfunction

  function automatic wide_t ins_rd(input wide_t ins, input int rw, input int dw);
    return (ins >> (dw + rw)) & fmask(rw);
  endfunction

  function automatic wide_t ins_rs(input wide_t ins, input int rw, input int dw);
    return (ins >> dw) & fmask(rw);
  endfunction

  function automatic wide_t ins_imm(input wide_t ins, input int dw);
    return ins & fmask(dw);
  endfunction

endpackage

// File: rtl/pico_alu.sv
// Combinational ALU: result and carry/borrow for one opcode; non-ALU opcodes pass a through.
module pico_alu
  import pico_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_ADDI: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:          {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_SHL:          {carry, result} = {a, 1'b0};
      OP_SHR:          {result, carry} = {1'b0, a};
      default:         result = a;
    endcase
  end

endmodule

// File: rtl/pico_core_mc.sv
// Multi-cycle pico core: fetch/wait/exec sequencing, GPR file, flags and valid/ready I/O.
// The first cycle after reset release is an idle fetch slot so imem_en stays low through reset.
module pico_core_mc
  import pico_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 6,
  localparam int RW  = $clog2(NREG),
  localparam int IW  = 4 + 2*RW + DW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign,
  output logic          zero,
  output logic          carry,
  output logic          halted
);

  state_e        state, state_nxt;
  logic          run;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic [DW-1:0] regs [NREG];

  op_e           op;
  logic [RW-1:0] rd, rs;
  logic [DW-1:0] imm, rd_val, rs_val, alu_b, alu_res;
  logic          alu_c;

  assign op     = op_e'(ins_op(wide_t'(ir), IW));
  assign rd     = RW'(ins_rd(wide_t'(ir), RW, DW));
  assign rs     = RW'(ins_rs(wide_t'(ir), RW, DW));
  assign imm    = DW'(ins_imm(wide_t'(ir), DW));
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];
  assign alu_b  = (op == OP_ADDI) ? imm : rs_val;

  pico_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_en = run;
        if (run) state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_IN:   state_nxt = S_IN_WAIT;
          OP_OUT:  state_nxt = S_OUT_WAIT;
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_IN_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_FETCH;
      end
      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      pc       <= '0;
      ir       <= '0;
      out_data <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_WAIT: ir <= imem_data;
        S_EXEC: begin
          pc <= pc + AW'(1);
          case (op)
            OP_LDI: regs[rd] <= imm;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI: begin
              regs[rd] <= alu_res;
              sign     <= alu_res[DW-1];
              zero     <= (alu_res == '0);
              if (op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ADDI}) carry <= alu_c;
            end
            OP_BEQZ: if (rd_val == '0) pc <= imm[AW-1:0];
            OP_JMP:  pc <= imm[AW-1:0];
            OP_OUT:  out_data <= rs_val;
            // IN advances pc on its handshake; HALT never advances.
            OP_IN, OP_HALT: pc <= pc;
            default: ;
          endcase
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            regs[rd] <= in_data;
            pc       <= pc + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_core_mc.sv
// Directed bench for pico_core_mc: ALU vector table plus hand-written flow/stall/reset sequences.
module tb_pico_core_mc;
  import pico_pkg::*;

  logic        clk, rst_n;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        sign, zero, carry, halted;

  pico_core_mc dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .zero(zero), .carry(carry), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  int         fetch_cnt, out_cnt, in_cnt;
  logic [7:0] out_last;
  logic [5:0] trace [$];
  always @(negedge clk) begin
    if (!rst_n) begin
      fetch_cnt = 0; out_cnt = 0; in_cnt = 0; out_last = 8'h00;
      trace.delete();
    end else begin
      if (imem_en) begin fetch_cnt++; trace.push_back(imem_addr); end
      if (out_valid && out_ready) begin out_cnt++; out_last = out_data; end
      if (in_valid && in_ready) in_cnt++;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string nm, input int maxc);
    int c = 0;
    while (!halted && c < maxc) begin tick(); c++; end
    chk(nm, halted, 1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic       c, s, z;
  } vec_t;
  vec_t vecs [11];

  logic [5:0] exp_tr [10];
  logic [5:0] exp_wr [7];
  logic       ok;
  int         f0, c;

  initial begin
    vecs[0]  = '{OP_ADD,  8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  8'h02, 8'h03, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_AND,  8'hCC, 8'hAA, 8'h88, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{OP_OR,   8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR,  8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{OP_SHL,  8'h80, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{OP_SHR,  8'h81, 8'h11, 8'h40, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADDI, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_LDI,  8'h11, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
    exp_tr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd4};
    exp_wr = '{6'd0, 6'd3, 6'd4, 6'd63, 6'd0, 6'd1, 6'd2};

    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    hold_reset();
    #1;
    chk("rst imem_en", imem_en, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst halted", halted, 0);
    chk("rst flags", {sign, zero, carry}, 0);

    // Basic program: 5+3 emitted, then halt.
    mem[0] = enc(OP_LDI, 0, 0, 8'h05);
    mem[1] = enc(OP_LDI, 1, 0, 8'h03);
    mem[2] = enc(OP_ADD, 0, 1, 8'h00);
    mem[3] = enc(OP_OUT, 0, 0, 8'h00);
    mem[4] = enc(OP_HALT, 0, 0, 8'h00);
    release_reset();
    run_to_halt("t1 halt", 100);
    chk("t1 out_data", out_last, 8'h08);
    chk("t1 out count", out_cnt, 1);
    chk("t1 fetches", fetch_cnt, 5);
    repeat (5) tick();
    chk("t1 fetches after halt", fetch_cnt, 5);
    chk("t1 imem_en in halt", imem_en, 0);

    // ALU vector table.
    for (int i = 0; i < 11; i++) begin
      hold_reset();
      mem[0] = enc(OP_LDI, 0, 0, vecs[i].a);
      mem[1] = enc(OP_LDI, 1, 0, vecs[i].b);
      mem[2] = enc(vecs[i].op, 0, 1, vecs[i].b);
      mem[3] = enc(OP_OUT, 0, 0, 8'h00);
      mem[4] = enc(OP_HALT, 0, 0, 8'h00);
      release_reset();
      run_to_halt($sformatf("v%0d halt", i), 100);
      chk($sformatf("v%0d result", i), out_last, vecs[i].res);
      chk($sformatf("v%0d carry", i), carry, vecs[i].c);
      chk($sformatf("v%0d sign", i), sign, vecs[i].s);
      chk($sformatf("v%0d zero", i), zero, vecs[i].z);
    end

    // Countdown loop with BEQZ exit.
    hold_reset();
    mem[0] = enc(OP_LDI, 0, 0, 8'h03);
    mem[1] = enc(OP_ADDI, 0, 0, 8'hFF);
    mem[2] = enc(OP_BEQZ, 0, 0, 8'h04);
    mem[3] = enc(OP_JMP, 0, 0, 8'h01);
    mem[4] = enc(OP_HALT, 0, 0, 8'h00);
    release_reset();
    run_to_halt("t3 halt", 200);
    chk("t3 trace len", trace.size(), 10);
    for (int i = 0; i < 10 && i < trace.size(); i++)
      chk($sformatf("t3 pc[%0d]", i), trace[i], exp_tr[i]);
    chk("t3 zero", zero, 1);

    // Input stall: 10 cycles without valid, then one valid cycle.
    hold_reset();
    mem[0] = enc(OP_IN, 2, 0, 8'h00);
    mem[1] = enc(OP_OUT, 0, 2, 8'h00);
    mem[2] = enc(OP_HALT, 0, 0, 8'h00);
    in_data = 8'h33;
    release_reset();
    c = 0;
    while (!in_ready && c < 50) begin tick(); c++; end
    chk("t4 in_ready seen", in_ready, 1);
    f0 = fetch_cnt; ok = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); ok &= in_ready; end
    chk("t4 in_ready held", ok, 1);
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t4 in_ready drop", in_ready, 0);
    chk("t4 no fetch in stall", fetch_cnt, f0);
    run_to_halt("t4 halt", 100);
    chk("t4 in count", in_cnt, 1);
    chk("t4 data", out_last, 8'hA5);

    // Output stall: 7 cycles without ready.
    hold_reset();
    out_ready = 1'b0;
    mem[0] = enc(OP_LDI, 3, 0, 8'h5C);
    mem[1] = enc(OP_OUT, 0, 3, 8'h00);
    mem[2] = enc(OP_HALT, 0, 0, 8'h00);
    release_reset();
    c = 0;
    while (!out_valid && c < 50) begin tick(); c++; end
    chk("t5 out_valid seen", out_valid, 1);
    f0 = fetch_cnt; ok = 1'b1;
    for (int i = 0; i < 7; i++) begin tick(); ok &= out_valid && (out_data == 8'h5C); end
    chk("t5 out stable", ok, 1);
    chk("t5 no fetch in stall", fetch_cnt, f0);
    out_ready = 1'b1;
    tick();
    chk("t5 out_valid drop", out_valid, 0);
    chk("t5 out_data kept", out_data, 8'h5C);
    chk("t5 refetch en", imem_en, 1);
    chk("t5 refetch addr", imem_addr, 2);
    run_to_halt("t5 halt", 50);

    // Reset during OUT_WAIT with non-zero flags.
    hold_reset();
    out_ready = 1'b0;
    mem[0] = enc(OP_LDI, 0, 0, 8'hFF);
    mem[1] = enc(OP_ADDI, 0, 0, 8'h81);
    mem[2] = enc(OP_OUT, 0, 0, 8'h00);
    release_reset();
    c = 0;
    while (!out_valid && c < 50) begin tick(); c++; end
    chk("t6 out_valid seen", out_valid, 1);
    chk("t6 flags before", {sign, zero, carry}, 3'b101);
    rst_n = 1'b0; #1;
    chk("t6 rst out_valid", out_valid, 0);
    chk("t6 rst out_data", out_data, 0);
    chk("t6 rst flags", {sign, zero, carry}, 0);
    chk("t6 rst imem_addr", imem_addr, 0);
    hold_reset();
    out_ready = 1'b1;
    mem[0] = enc(OP_OUT, 0, 0, 8'h00);
    mem[1] = enc(OP_HALT, 0, 0, 8'h00);
    release_reset();
    c = 0;
    while (!imem_en && c < 10) begin tick(); c++; end
    chk("t6 restart fetch", imem_en, 1);
    chk("t6 restart addr", imem_addr, 0);
    run_to_halt("t6 halt", 50);
    chk("t6 r0 cleared", out_last, 0);

    // Reset during IN_WAIT coinciding with valid data: no write.
    hold_reset();
    mem[0] = enc(OP_IN, 1, 0, 8'h00);
    release_reset();
    c = 0;
    while (!in_ready && c < 50) begin tick(); c++; end
    chk("t6i in_ready seen", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h77;
    rst_n = 1'b0; #1;
    chk("t6i rst in_ready", in_ready, 0);
    chk("t6i rst halted", halted, 0);
    hold_reset();
    in_valid = 1'b0;
    mem[0] = enc(OP_OUT, 0, 1, 8'h00);
    mem[1] = enc(OP_HALT, 0, 0, 8'h00);
    release_reset();
    run_to_halt("t6i halt", 50);
    chk("t6i no write", out_last, 0);
    chk("t6i in count", in_cnt, 0);

    // PC wrap via JMP to the last address; also a not-taken BEQZ.
    hold_reset();
    mem[0]  = enc(OP_BEQZ, 0, 0, 8'h03);
    mem[1]  = enc(OP_OUT, 0, 0, 8'h00);
    mem[2]  = enc(OP_HALT, 0, 0, 8'h00);
    mem[3]  = enc(OP_LDI, 0, 0, 8'h01);
    mem[4]  = enc(OP_JMP, 0, 0, 8'h3F);
    mem[63] = enc(OP_NOP, 0, 0, 8'h00);
    release_reset();
    run_to_halt("tw halt", 100);
    chk("tw trace len", trace.size(), 7);
    for (int i = 0; i < 7 && i < trace.size(); i++)
      chk($sformatf("tw pc[%0d]", i), trace[i], exp_wr[i]);
    chk("tw out", out_last, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
